// File: rtl/ob_ram_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ob_ram_streamer
// Description : Streams a packet out of the outbound RAM onto an AXI-Stream
//               master once the core signals that the packet is written.
//               Keeps at most two words outstanding (buffered + in flight),
//               sustains one beat per cycle with m_tready high, and pulses
//               RamFree when the RAM may be rewritten.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               DataReady, DataLen   - packet-written pulse and length (words)
//               enableUseRam         - gates acceptance of DataReady
//               RamFree, ReqDropped  - RAM drained / request ignored pulses
//               Busy                 - packet accepted, RamFree not yet done
//               ram_rd_en/addr/data  - RAM read port (1-cycle read latency)
//               m_tdata/tvalid/tready/tlast - AXI-Stream master
// Revision    : 1.0 - initial release
// ============================================================================
module ob_ram_streamer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DataReady,
    input  logic [ADDR_W:0]   DataLen,
    input  logic              enableUseRam,
    output logic              RamFree,
    output logic              ReqDropped,
    output logic              Busy,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_beat;
    logic              r_rd_pend;
    logic [1:0]        r_count;
    logic              r_wp;
    logic              r_rp;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_drop;

    logic              w_accept;
    logic              w_pop;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W:0]   w_len_sat;
    logic [DATA_W-1:0] w_head;

    assign w_len_sat = (DataLen > c_DEPTH) ? c_DEPTH : DataLen;
    assign w_accept  = (r_state == c_IDLE) & DataReady & enableUseRam;

    // The word returning from the RAM this cycle counts as buffer content,
    // so an empty buffer presents it directly; this gives the one-cycle
    // read-to-beat latency without an extra register stage.
    assign m_tvalid = (r_count != 2'd0) | r_rd_pend;
    assign w_head   = (r_count == 2'd0) ? ram_rd_data : r_buf[r_rp];
    assign m_tdata  = m_tvalid ? w_head : '0;
    assign m_tlast  = m_tvalid & (r_beat == (r_len - c_ONE));
    assign w_pop    = m_tvalid & m_tready;

    // A returning word taken straight through the bypass never enters storage.
    assign w_wr = r_rd_pend & ~((r_count == 2'd0) & w_pop);
    assign w_rd = w_pop & (r_count != 2'd0);

    assign Busy        = (r_state != c_IDLE);
    assign RamFree     = (r_state == c_DONE);
    assign ReqDropped  = r_drop;
    assign ram_rd_addr = r_issued[ADDR_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        ram_rd_en   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (DataLen == '0) ? c_DONE : c_STREAM;
                end
            end
            c_STREAM: begin
                // Occupancy includes the read in flight, capping outstanding words at two.
                ram_rd_en = (r_issued < r_len) &&
                            ((r_count + {1'b0, r_rd_pend}) < 2'd2);
                if (w_pop && m_tlast) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_len     <= '0;
            r_issued  <= '0;
            r_beat    <= '0;
            r_rd_pend <= 1'b0;
            r_count   <= 2'd0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drop    <= DataReady & (r_state != c_IDLE);
            r_rd_pend <= ram_rd_en;
            if (w_accept) begin
                r_len    <= w_len_sat;
                r_issued <= '0;
                r_beat   <= '0;
            end else begin
                if (ram_rd_en) begin
                    r_issued <= r_issued + c_ONE;
                end
                if (w_pop) begin
                    r_beat <= r_beat + c_ONE;
                end
            end
            if (w_wr) begin
                r_wp <= ~r_wp;
            end
            if (w_rd) begin
                r_rp <= ~r_rp;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

    // Buffer storage needs no reset: it is only visible while r_count says so.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wp] <= ram_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ob_ram_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ob_ram_streamer
// Description : Self-checking bench for ob_ram_streamer. A transaction-level
//               model (packet length, words issued, words accepted) predicts
//               every output each cycle; literal timing checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ob_ram_streamer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              DataReady;
    logic [ADDR_W:0]   DataLen;
    logic              enableUseRam;
    logic              RamFree, ReqDropped, Busy, ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid, m_tready, m_tlast;

    ob_ram_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .DataReady(DataReady), .DataLen(DataLen),
        .enableUseRam(enableUseRam), .RamFree(RamFree), .ReqDropped(ReqDropped),
        .Busy(Busy), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, garbage on cycles without a read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) ram_rd_data <= ram_rd_en ? mem[ram_rd_addr] : DATA_W'($urandom);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit m_act = 0, m_free = 0, m_drop = 0;
    int m_len = 0, m_iss = 0, m_acc = 0;
    bit e_rd, e_v, idle_pre;

    // per-packet observations for literal checks
    int acc_cyc = 0, n_acc = 0;
    int beats = 0, first_rd = -1, first_valid = -1, free_cyc = -1;
    int last_addr = -1, tlast_beat = -1, obs_rd = 0, max_out = 0, drop_cyc = -1;

    always @(negedge clk) begin
        e_rd = m_act && (m_iss < m_len) && ((m_iss - m_acc) < 2);
        e_v  = m_act && (m_acc < m_iss);
        chk("busy",       Busy,       m_act || m_free);
        chk("ramfree",    RamFree,    m_free);
        chk("reqdropped", ReqDropped, m_drop);
        chk("rd_en",      ram_rd_en,  e_rd);
        if (e_rd) chk("rd_addr", ram_rd_addr, m_iss);
        chk("tvalid", m_tvalid, e_v);
        if (e_v) begin
            chk("tdata", m_tdata, mem[m_acc]);
            chk("tlast", m_tlast, m_acc == m_len - 1);
        end

        if (ram_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            last_addr = ram_rd_addr;
            obs_rd++;
            if (obs_rd - beats > max_out) max_out = obs_rd - beats;
        end
        if (m_tvalid && first_valid < 0) first_valid = cyc;
        if (m_tvalid && m_tready) begin
            if (m_tlast) tlast_beat = beats;
            beats++;
        end
        if (RamFree)    free_cyc = cyc;
        if (ReqDropped) drop_cyc = cyc;

        // advance the model across the coming clock edge
        idle_pre = !m_act && !m_free;
        m_drop   = DataReady && !idle_pre;
        m_free   = 0;
        if (m_act) begin
            if (e_rd) m_iss++;
            if (e_v && m_tready) begin
                m_acc++;
                if (m_acc == m_len) begin
                    m_act  = 0;
                    m_free = 1;
                end
            end
        end else if (idle_pre && DataReady && enableUseRam) begin
            m_len = (int'(DataLen) > DEPTH) ? DEPTH : int'(DataLen);
            m_iss = 0;
            m_acc = 0;
            acc_cyc = cyc;
            n_acc++;
            beats = 0; first_rd = -1; first_valid = -1; free_cyc = -1;
            last_addr = -1; tlast_beat = -1; obs_rd = 0; max_out = 0;
            if (m_len == 0) m_free = 1;
            else            m_act  = 1;
        end
        if (rst) begin
            m_act = 0; m_free = 0; m_drop = 0; m_iss = 0; m_acc = 0;
        end
    end

    // ---------------- m_tready driver ----------------
    int mode = 0;   // 0: always ready, 1: random, 2: stalled
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int len, input bit en);
        @(posedge clk);
        #2;
        DataReady    = 1'b1;
        DataLen      = (ADDR_W+1)'(len);
        enableUseRam = en;
        @(posedge clk);
        #2;
        DataReady = 1'b0;
    endtask

    task automatic pulse(output int pc);
        @(posedge clk);
        #2;
        DataReady = 1'b1;
        pc = cyc;
        @(posedge clk);
        #2;
        DataReady = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        #1;
        while ((m_act || m_free) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (m_act || m_free) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout at cycle %0d: still busy, expected idle within %0d cycles", cyc, budget);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},    Busy,        0);
        chk({tag, "_ramfree"}, RamFree,     0);
        chk({tag, "_dropped"}, ReqDropped,  0);
        chk({tag, "_rd_en"},   ram_rd_en,   0);
        chk({tag, "_tvalid"},  m_tvalid,    0);
        chk({tag, "_tlast"},   m_tlast,     0);
        chk({tag, "_rd_addr"}, ram_rd_addr, 0);
        chk({tag, "_tdata"},   m_tdata,     0);
    endtask

    int c0, pc, d0, n0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst = 1'b1; DataReady = 1'b0; DataLen = '0; enableUseRam = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check_outputs_zero("reset");

        // 4-word packet, always ready
        send(4, 1'b1);
        wait_idle(100);
        c0 = acc_cyc;
        chk("len4_first_rd",    first_rd,    c0 + 1);
        chk("len4_first_valid", first_valid, c0 + 2);
        chk("len4_ramfree",     free_cyc,    c0 + 6);
        chk("len4_beats",       beats,       4);
        chk("len4_last_addr",   last_addr,   3);
        chk("len4_tlast_beat",  tlast_beat,  3);

        // 4-word packet, sink stalled for 5 cycles from the first valid cycle
        mode = 2;
        send(4, 1'b1);
        c0 = acc_cyc;
        while (cyc < c0 + 6) begin
            @(negedge clk);
            #1;
        end
        mode = 0;
        wait_idle(100);
        chk("stall_beats",      beats,      4);
        chk("stall_max_out",    max_out,    2);
        chk("stall_tlast_beat", tlast_beat, 3);
        chk("stall_ramfree",    free_cyc,   c0 + 11);

        // single word and empty packets
        send(1, 1'b1);
        wait_idle(100);
        chk("len1_beats",      beats,      1);
        chk("len1_tlast_beat", tlast_beat, 0);
        chk("len1_ramfree",    free_cyc,   acc_cyc + 3);
        send(0, 1'b1);
        wait_idle(100);
        chk("len0_beats",    beats,    0);
        chk("len0_first_rd", first_rd, -1);
        chk("len0_ramfree",  free_cyc, acc_cyc + 1);

        // request while streaming is dropped; disabled request is ignored
        send(8, 1'b1);
        n0 = n_acc;
        pulse(pc);
        wait_idle(100);
        chk("busy_drop_cycle", drop_cyc, pc + 1);
        chk("busy_drop_beats", beats,    8);
        chk("busy_drop_nacc",  n_acc,    n0);
        d0 = drop_cyc;
        n0 = n_acc;
        send(5, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        chk("disabled_nacc", n_acc,    n0);
        chk("disabled_drop", drop_cyc, d0);

        // oversized length saturates to DEPTH
        send(DEPTH + 1, 1'b1);
        wait_idle(200);
        chk("sat_beats",     beats,     DEPTH);
        chk("sat_last_addr", last_addr, DEPTH - 1);
        chk("sat_ramfree",   free_cyc,  acc_cyc + DEPTH + 2);

        // reset in the middle of an 8-word packet
        send(8, 1'b1);
        while (m_acc < 2) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check_outputs_zero("midrst");
        chk("midrst_no_ramfree", free_cyc, -1);
        send(8, 1'b1);
        wait_idle(100);
        chk("after_rst_beats",     beats,     8);
        chk("after_rst_last_addr", last_addr, 7);

        // randomized traffic
        mode = 1;
        for (int p = 0; p < 40; p++) begin
            send($urandom_range(0, DEPTH + 4), $urandom_range(0, 3) != 0);
            enableUseRam = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                pulse(pc);
            end
            wait_idle(400);
        end
        mode = 0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ob_ram_streamer.md
OB_RAM_STREAMER -- requirements
Module: ob_ram_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning RAM word / stream data width.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning RAM address width; DEPTH = 2^ADDR_W words.
REQ-003 SHALL have port clk, input, 1, meaning single clock for all logic.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port DataReady, input, 1, meaning 1-cycle pulse: core finished writing a packet into the outbound RAM.
REQ-006 SHALL have port DataLen, input, ADDR_W+1, meaning packet length in words; valid with DataReady.
REQ-007 SHALL have port enableUseRam, input, 1, meaning gates acceptance of DataReady.
REQ-008 SHALL have port RamFree, output, 1, meaning 1-cycle pulse: RAM drained and may be rewritten.
REQ-009 SHALL have port ReqDropped, output, 1, meaning 1-cycle pulse: DataReady ignored because block busy.
REQ-010 SHALL have port Busy, output, 1, meaning high from packet acceptance through RamFree cycle.
REQ-011 SHALL have port ram_rd_en, output, 1, meaning RAM read strobe.
REQ-012 SHALL have port ram_rd_addr, output, ADDR_W, meaning RAM read address.
REQ-013 SHALL have port ram_rd_data, input, DATA_W, meaning read data, valid exactly 1 cycle after ram_rd_en.
REQ-014 SHALL have ports m_tdata (output, DATA_W), m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1), meaning AXI-Stream master towards the DMA transmit path.

Function
REQ-015 SHALL implement states IDLE, STREAM, DONE.
REQ-016 In IDLE, DataReady & enableUseRam & DataLen!=0 SHALL latch len (values above DEPTH saturate to DEPTH), clear read address to 0, and enter STREAM.
REQ-017 In IDLE, DataReady & enableUseRam & DataLen==0 SHALL enter DONE directly, producing no beats.
REQ-018 In IDLE, DataReady with enableUseRam=0 SHALL be ignored without ReqDropped.
REQ-019 DataReady in STREAM or DONE SHALL be ignored and SHALL pulse ReqDropped the next cycle.
REQ-020 In STREAM, a read SHALL be issued when issued count < len and (buffered words + reads in flight) < 2; ram_rd_addr SHALL increment by 1 per issued read, starting at 0.
REQ-021 Returned read data SHALL land in a 2-entry output buffer; m_tvalid = buffer not empty; m_tdata = oldest entry.
REQ-022 m_tdata and m_tlast SHALL hold stable while m_tvalid & ~m_tready.
REQ-023 m_tlast SHALL be high exactly on beat index len-1.
REQ-024 Handshake of the tlast beat SHALL move to DONE; DONE SHALL assert RamFree for one cycle and then return to IDLE.
REQ-025 Latency: DataReady sampled at edge T -> ram_rd_en at cycle T+1 (addr 0) -> m_tvalid at T+2.
REQ-026 With m_tready held high, throughput SHALL be 1 beat/cycle; packet of N words SHALL have RamFree in cycle T+N+2.
REQ-027 Deasserting enableUseRam mid-packet SHALL NOT affect the packet in progress.
REQ-028 A new packet SHALL be acceptable in the cycle after RamFree (no further gap).
REQ-029 ram_rd_en SHALL never be issued outside STREAM or beyond len reads.

Reset
REQ-030 rst SHALL force IDLE, clear counters and output buffer; Busy, RamFree, ReqDropped, ram_rd_en, m_tvalid, m_tlast SHALL be 0; ram_rd_addr and m_tdata SHALL be 0.
REQ-031 rst mid-packet SHALL abort the packet with no RamFree and discard buffered data; read data returning the cycle after rst SHALL be dropped.

Verification
REQ-032 DataReady, DataLen=4, m_tready=1 -> ram_rd_addr 0..3 on T+1..T+4, 4 beats T+2..T+5, m_tlast on beat 3, RamFree at T+6.
REQ-033 DataLen=4, m_tready low for 5 cycles from T+2 -> at most 2 reads outstanding, beat 0 data held stable, no data loss or duplication, tlast on beat 3.
REQ-034 DataLen=1 -> single beat with m_tlast=1; DataLen=0 -> no beats, RamFree one cycle after acceptance.
REQ-035 DataReady pulse during STREAM -> ReqDropped next cycle, current packet unchanged; enableUseRam=0 in IDLE -> no acceptance, no ReqDropped.
REQ-036 DataLen=DEPTH+1 -> DEPTH beats, last address DEPTH-1, then RamFree.
REQ-037 rst asserted at beat 2 of 8 -> all outputs 0 next cycle, no RamFree, next DataReady streams from address 0.
